// File: rtl/psram_arbiter.sv
// Two-port arbiter in front of a single PsramController: gates traffic until the controller
// is idle after power-up, grants one request at a time and returns read data with an ack.
module psram_arbiter #(
  parameter int unsigned ADDR_W     = 22,
  parameter bit          FIXED_PRIO = 1'b0,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_write,
  input  logic              p0_byte,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [15:0]       p0_wdata,
  output logic              p0_ack,
  output logic [15:0]       p0_rdata,
  input  logic              p1_req,
  input  logic              p1_write,
  input  logic              p1_byte,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [15:0]       p1_wdata,
  output logic              p1_ack,
  output logic [15:0]       p1_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_byte_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_din,
  input  logic [15:0]       mem_dout,
  input  logic              mem_busy,
  output logic              ready,
  output logic              error,
  output logic              err_port
);

  typedef enum logic [2:0] {StInit, StIdle, StIssue, StSettle, StWait} state_e;

  localparam logic [7:0] WdLimit = 8'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              idle_seen_q, idle_seen_d;
  logic              ready_q, ready_d;
  logic              error_q, error_d;
  logic              err_port_q, err_port_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic              write_q, write_d;
  logic              byte_q, byte_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       din_q, din_d;
  logic [7:0]        wd_q, wd_d;
  logic              p0_ack_q, p0_ack_d;
  logic              p1_ack_q, p1_ack_d;
  logic [15:0]       p0_rdata_q, p0_rdata_d;
  logic [15:0]       p1_rdata_q, p1_rdata_d;
  logic              pick;

  always_comb begin
    state_d      = state_q;
    idle_seen_d  = idle_seen_q;
    ready_d      = ready_q;
    error_d      = error_q;
    err_port_d   = err_port_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    write_d      = write_q;
    byte_d       = byte_q;
    addr_d       = addr_q;
    din_d        = din_q;
    wd_d         = wd_q;
    p0_ack_d     = 1'b0;
    p1_ack_d     = 1'b0;
    p0_rdata_d   = p0_rdata_q;
    p1_rdata_d   = p1_rdata_q;

    if (p0_req && p1_req) begin
      pick = FIXED_PRIO ? 1'b0 : ~last_grant_q;
    end else begin
      pick = p1_req;
    end

    case (state_q)
      StInit: begin
        // Controller counts as initialised after two consecutive idle samples.
        if (!mem_busy) begin
          if (idle_seen_q) begin
            idle_seen_d = 1'b0;
            ready_d     = 1'b1;
            state_d     = StIdle;
          end else begin
            idle_seen_d = 1'b1;
          end
        end else begin
          idle_seen_d = 1'b0;
        end
      end
      StIdle: begin
        if (p0_req || p1_req) begin
          grant_d      = pick;
          last_grant_d = pick;
          write_d      = pick ? p1_write : p0_write;
          byte_d       = pick ? p1_byte  : p0_byte;
          addr_d       = pick ? p1_addr  : p0_addr;
          din_d        = pick ? p1_wdata : p0_wdata;
          state_d      = StIssue;
        end
      end
      StIssue: begin
        wd_d    = 8'd0;
        state_d = StSettle;
      end
      StSettle: begin
        // Controller raises busy one cycle after the pulse, so busy is not trusted here.
        wd_d    = wd_q + 8'd1;
        state_d = StWait;
      end
      StWait: begin
        if (!mem_busy) begin
          if (!write_q) begin
            if (grant_q) p1_rdata_d = mem_dout;
            else         p0_rdata_d = mem_dout;
          end
          p0_ack_d = ~grant_q;
          p1_ack_d = grant_q;
          state_d  = StIdle;
        end else if (wd_q == WdLimit) begin
          error_d     = 1'b1;
          err_port_d  = grant_q;
          p0_ack_d    = ~grant_q;
          p1_ack_d    = grant_q;
          ready_d     = 1'b0;
          idle_seen_d = 1'b0;
          state_d     = StInit;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StInit;
      idle_seen_q  <= 1'b0;
      ready_q      <= 1'b0;
      error_q      <= 1'b0;
      err_port_q   <= 1'b0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      write_q      <= 1'b0;
      byte_q       <= 1'b0;
      addr_q       <= '0;
      din_q        <= 16'd0;
      wd_q         <= 8'd0;
      p0_ack_q     <= 1'b0;
      p1_ack_q     <= 1'b0;
      p0_rdata_q   <= 16'd0;
      p1_rdata_q   <= 16'd0;
    end else begin
      state_q      <= state_d;
      idle_seen_q  <= idle_seen_d;
      ready_q      <= ready_d;
      error_q      <= error_d;
      err_port_q   <= err_port_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      write_q      <= write_d;
      byte_q       <= byte_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      wd_q         <= wd_d;
      p0_ack_q     <= p0_ack_d;
      p1_ack_q     <= p1_ack_d;
      p0_rdata_q   <= p0_rdata_d;
      p1_rdata_q   <= p1_rdata_d;
    end
  end

  assign mem_read       = (state_q == StIssue) && !write_q;
  assign mem_write      = (state_q == StIssue) && write_q;
  assign mem_byte_write = byte_q;
  assign mem_addr       = addr_q;
  assign mem_din        = din_q;
  assign p0_ack         = p0_ack_q;
  assign p1_ack         = p1_ack_q;
  assign p0_rdata       = p0_rdata_q;
  assign p1_rdata       = p1_rdata_q;
  assign ready          = ready_q;
  assign error          = error_q;
  assign err_port       = err_port_q;

endmodule

// File: tb/tb_psram_arbiter.sv
// Directed bench for psram_arbiter: a round-robin and a fixed-priority instance share stimulus
// and a simple busy model of the controller.
module tb_psram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req, p0_write, p0_byte, p1_req, p1_write, p1_byte;
  logic [21:0] p0_addr, p1_addr;
  logic [15:0] p0_wdata, p1_wdata;
  logic [15:0] mem_dout;
  logic        mem_busy;
  logic        busy_hold;
  int          lat;
  int          busy_cnt;

  logic        d0_p0_ack, d0_p1_ack, d0_rd, d0_wr, d0_bw, d0_ready, d0_error, d0_err_port;
  logic [15:0] d0_p0_rdata, d0_p1_rdata, d0_din;
  logic [21:0] d0_addr;
  logic        d1_p0_ack, d1_p1_ack, d1_rd, d1_wr, d1_bw, d1_ready, d1_error, d1_err_port;
  logic [15:0] d1_p0_rdata, d1_p1_rdata, d1_din;
  logic [21:0] d1_addr;

  int errors = 0;
  int checks = 0;

  logic [21:0] d0_addr_log[$];
  logic [21:0] d1_addr_log[$];
  bit          ack_order[$];

  always #5 clk = ~clk;

  psram_arbiter #(.ADDR_W(22), .FIXED_PRIO(1'b0), .TIMEOUT(64)) dut0 (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_write(p0_write), .p0_byte(p0_byte), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_ack(d0_p0_ack), .p0_rdata(d0_p0_rdata),
    .p1_req(p1_req), .p1_write(p1_write), .p1_byte(p1_byte), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_ack(d0_p1_ack), .p1_rdata(d0_p1_rdata),
    .mem_read(d0_rd), .mem_write(d0_wr), .mem_byte_write(d0_bw), .mem_addr(d0_addr),
    .mem_din(d0_din), .mem_dout(mem_dout), .mem_busy(mem_busy),
    .ready(d0_ready), .error(d0_error), .err_port(d0_err_port)
  );

  psram_arbiter #(.ADDR_W(22), .FIXED_PRIO(1'b1), .TIMEOUT(64)) dut1 (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_write(p0_write), .p0_byte(p0_byte), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_ack(d1_p0_ack), .p0_rdata(d1_p0_rdata),
    .p1_req(p1_req), .p1_write(p1_write), .p1_byte(p1_byte), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_ack(d1_p1_ack), .p1_rdata(d1_p1_rdata),
    .mem_read(d1_rd), .mem_write(d1_wr), .mem_byte_write(d1_bw), .mem_addr(d1_addr),
    .mem_din(d1_din), .mem_dout(mem_dout), .mem_busy(mem_busy),
    .ready(d1_ready), .error(d1_error), .err_port(d1_err_port)
  );

  // Busy model: seen by the arbiter from the cycle after the pulse for lat cycles.
  always @(negedge clk or posedge reset) begin
    if (reset) busy_cnt <= 0;
    else if (d0_rd || d0_wr) busy_cnt <= lat + 1;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign mem_busy = busy_hold || (busy_cnt != 0);

  always @(negedge clk) begin
    if (d0_rd || d0_wr) d0_addr_log.push_back(d0_addr);
    if (d1_rd || d1_wr) d1_addr_log.push_back(d1_addr);
  end

  task automatic wait_ack(input bit dut, input bit port, input int budget, output int cycles);
    logic a;
    cycles = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      a = dut ? (port ? d1_p1_ack : d1_p0_ack) : (port ? d0_p1_ack : d0_p0_ack);
      if (a) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic wait_acks(input bit dut, input int n, input int budget, output int got);
    got = 0;
    for (int i = 0; i < budget && got < n; i++) begin
      @(negedge clk);
      if (dut ? d1_p0_ack : d0_p0_ack) begin ack_order.push_back(1'b0); got++; end
      if (dut ? d1_p1_ack : d0_p1_ack) begin ack_order.push_back(1'b1); got++; end
    end
  endtask

  task automatic reset_and_init();
    int c;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    busy_hold = 1'b0;
    c = 0;
    while (!d0_ready && c < 10) begin @(negedge clk); c++; end
    checks++;
    if (d0_ready !== 1'b1) begin
      errors++;
      $display("FAIL reinit_ready: got %0b want 1", d0_ready);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({d0_ready, d0_error, d0_err_port, d0_p0_ack, d0_p1_ack} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 00000",
               {d0_ready, d0_error, d0_err_port, d0_p0_ack, d0_p1_ack});
    end
    checks++;
    if ({d0_p0_rdata, d0_p1_rdata, d0_din} !== 48'd0) begin
      errors++;
      $display("FAIL reset_data: got %h want 0", {d0_p0_rdata, d0_p1_rdata, d0_din});
    end
    checks++;
    if ({d0_rd, d0_wr, d0_bw, d0_addr} !== 25'd0) begin
      errors++;
      $display("FAIL reset_mem: got %h want 0", {d0_rd, d0_wr, d0_bw, d0_addr});
    end
  endtask

  task automatic test_init_gating();
    int bad, cyc;
    reset = 1'b0;
    p0_write = 1'b0; p0_addr = 22'h40; p0_req = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (d0_rd || d0_wr || d0_ready) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL init_gating: got %0d active cycles want 0", bad);
    end
    busy_hold = 1'b0;
    @(negedge clk);
    checks++;
    if (d0_ready !== 1'b0) begin
      errors++;
      $display("FAIL init_ready_early: got %0b want 0", d0_ready);
    end
    @(negedge clk);
    checks++;
    if (d0_ready !== 1'b1) begin
      errors++;
      $display("FAIL init_ready: got %0b want 1", d0_ready);
    end
    @(negedge clk);
    checks++;
    if (d0_rd !== 1'b1) begin
      errors++;
      $display("FAIL init_first_read: got %0b want 1", d0_rd);
    end
    wait_ack(1'b0, 1'b0, 40, cyc);
    p0_req = 1'b0;
    checks++;
    if (cyc == 0 || d0_addr_log.size() != 1) begin
      errors++;
      $display("FAIL init_single_read: got ack=%0d pulses=%0d want ack and 1 pulse",
               cyc, d0_addr_log.size());
    end
  endtask

  task automatic test_single_read();
    int cyc, base;
    logic [15:0] p1_before;
    lat = 10; mem_dout = 16'hA5C3;
    base = d0_addr_log.size();
    p1_before = d0_p1_rdata;
    p0_write = 1'b0; p0_addr = 22'h000123; p0_req = 1'b1;
    wait_ack(1'b0, 1'b0, 40, cyc);
    p0_req = 1'b0;
    checks++;
    if (cyc !== 13) begin
      errors++;
      $display("FAIL read_latency: got %0d want 13", cyc);
    end
    checks++;
    if (d0_p0_rdata !== 16'hA5C3) begin
      errors++;
      $display("FAIL read_data: got %h want a5c3", d0_p0_rdata);
    end
    checks++;
    if (d0_addr_log.size() != base + 1 || d0_addr_log[base] !== 22'h000123) begin
      errors++;
      $display("FAIL read_addr: got pulses=%0d want 1 at addr 000123",
               d0_addr_log.size() - base);
    end
    mem_dout = 16'h0000;
    @(negedge clk);
    checks++;
    if (d0_p0_ack !== 1'b0 || d0_p1_ack !== 1'b0 || d0_p0_rdata !== 16'hA5C3 ||
        d0_p1_rdata !== p1_before) begin
      errors++;
      $display("FAIL read_ack_pulse: got ack0=%0b ack1=%0b rdata=%h want 0 0 a5c3",
               d0_p0_ack, d0_p1_ack, d0_p0_rdata);
    end
  endtask

  task automatic test_round_robin();
    int got, base;
    logic [21:0] exp_addr[4];
    bit exp_port[4];
    exp_addr = '{22'h10, 22'h20, 22'h10, 22'h20};
    exp_port = '{1'b0, 1'b1, 1'b0, 1'b1};
    reset_and_init();
    lat = 3;
    ack_order.delete();
    base = d0_addr_log.size();
    p0_write = 1'b1; p0_addr = 22'h10; p0_wdata = 16'h1111;
    p1_write = 1'b1; p1_addr = 22'h20; p1_wdata = 16'h2222;
    p0_req = 1'b1; p1_req = 1'b1;
    wait_acks(1'b0, 4, 200, got);
    p0_req = 1'b0; p1_req = 1'b0;
    checks++;
    if (got !== 4 || d0_addr_log.size() < base + 4) begin
      errors++;
      $display("FAIL rr_count: got %0d acks want 4", got);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (d0_addr_log[base + i] !== exp_addr[i] || ack_order[i] !== exp_port[i]) begin
          errors++;
          $display("FAIL rr_order[%0d]: got addr=%h port=%0b want addr=%h port=%0b",
                   i, d0_addr_log[base + i], ack_order[i], exp_addr[i], exp_port[i]);
        end
      end
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_fixed_prio();
    int got, base, cyc;
    reset_and_init();
    lat = 3;
    ack_order.delete();
    base = d1_addr_log.size();
    p0_req = 1'b1; p1_req = 1'b1;
    wait_acks(1'b1, 3, 200, got);
    p0_req = 1'b0;
    checks++;
    if (got !== 3 || ack_order.size() != 3 ||
        ack_order[0] !== 1'b0 || ack_order[1] !== 1'b0 || ack_order[2] !== 1'b0) begin
      errors++;
      $display("FAIL prio_p0_wins: got %0d acks order=%p want 3 from port 0", got, ack_order);
    end
    checks++;
    if (d1_addr_log.size() < base + 3 || d1_addr_log[base + 2] !== 22'h10) begin
      errors++;
      $display("FAIL prio_addr: got %0d pulses want 3 at addr 10", d1_addr_log.size() - base);
    end
    wait_ack(1'b1, 1'b1, 40, cyc);
    p1_req = 1'b0;
    checks++;
    if (cyc == 0 || d1_addr_log[d1_addr_log.size() - 1] !== 22'h20) begin
      errors++;
      $display("FAIL prio_p1_after_drop: got ack=%0d addr=%h want ack at addr 20",
               cyc, d1_addr_log[d1_addr_log.size() - 1]);
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_byte_write();
    int c, cyc;
    p1_write = 1'b1; p1_byte = 1'b1; p1_addr = 22'h3FFFFF; p1_wdata = 16'h5A5A;
    p1_req = 1'b1;
    c = 0;
    do begin @(negedge clk); c++; end while (!d0_wr && c < 10);
    checks++;
    if ({d0_wr, d0_rd, d0_bw} !== 3'b101 || d0_din !== 16'h5A5A || d0_addr !== 22'h3FFFFF) begin
      errors++;
      $display("FAIL byte_write: got wr=%0b rd=%0b bw=%0b din=%h addr=%h want 1 0 1 5a5a 3fffff",
               d0_wr, d0_rd, d0_bw, d0_din, d0_addr);
    end
    wait_ack(1'b0, 1'b1, 40, cyc);
    p1_req = 1'b0; p1_byte = 1'b0;
    checks++;
    if (cyc == 0) begin
      errors++;
      $display("FAIL byte_ack: got no ack want ack");
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_timeout_reset();
    int cyc, acks;
    logic [15:0] rd_before;
    rd_before = d0_p1_rdata;
    mem_dout = 16'hBEEF;
    busy_hold = 1'b1;
    p1_write = 1'b0; p1_addr = 22'h55; p1_req = 1'b1;
    wait_ack(1'b0, 1'b1, 100, cyc);
    p1_req = 1'b0;
    checks++;
    if (cyc < 60 || cyc > 70) begin
      errors++;
      $display("FAIL timeout_ack: got %0d cycles want about 66", cyc);
    end
    checks++;
    if ({d0_error, d0_err_port, d0_ready} !== 3'b110 || d0_p1_rdata !== rd_before) begin
      errors++;
      $display("FAIL timeout_flags: got err=%0b port=%0b ready=%0b rdata=%h want 1 1 0 %h",
               d0_error, d0_err_port, d0_ready, d0_p1_rdata, rd_before);
    end
    busy_hold = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (d0_ready !== 1'b1 || d0_error !== 1'b1) begin
      errors++;
      $display("FAIL error_sticky: got ready=%0b err=%0b want 1 1", d0_ready, d0_error);
    end
    lat = 10;
    p0_write = 1'b0; p0_addr = 22'h77; p0_req = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({d0_ready, d0_error, d0_err_port, d0_p0_ack, d0_p1_ack, d0_rd, d0_wr, d0_bw} !== 8'd0 ||
        {d0_addr, d0_din, d0_p0_rdata, d0_p1_rdata} !== 70'd0) begin
      errors++;
      $display("FAIL reset_abort: got flags=%b addr=%h want all zero",
               {d0_ready, d0_error, d0_err_port, d0_p0_ack, d0_p1_ack, d0_rd, d0_wr, d0_bw},
               d0_addr);
    end
    p0_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    acks = 0;
    repeat (20) begin
      @(negedge clk);
      if (d0_p0_ack || d0_p1_ack) acks++;
    end
    checks++;
    if (acks !== 0) begin
      errors++;
      $display("FAIL reset_no_ack: got %0d acks want 0", acks);
    end
  endtask

  initial begin
    reset = 1'b1; busy_hold = 1'b1; lat = 10; mem_dout = 16'h0;
    p0_req = 1'b0; p0_write = 1'b0; p0_byte = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_req = 1'b0; p1_write = 1'b0; p1_byte = 1'b0; p1_addr = '0; p1_wdata = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_init_gating();
    test_single_read();
    test_round_robin();
    test_fixed_prio();
    test_byte_write();
    test_timeout_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
